// File: rtl/rv32_hart_fetch_sched_pkg.sv
// Shared RV32 datapath types plus the barrel-core constants used by the hart
// fetch scheduler.
package rv32_pkg;
    localparam int XLEN = 32;
    typedef logic [XLEN-1:0] rv32_pc_cnt_t;
    localparam rv32_pc_cnt_t PC_STEP = 32'd4;
endpackage

package pito_pkg;
    import rv32_pkg::*;
    localparam int NUM_HARTS = 8;
    localparam int HART_ID_W = $clog2(NUM_HARTS);
    typedef logic [HART_ID_W-1:0] hart_id_t;
    localparam rv32_pc_cnt_t RESET_PC = 32'h0000_0000;
endpackage

// File: rtl/rv32_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester found
// after the last-granted index, wrapping modulo N (N a power of two).
module rv32_rr_arbiter #(
    parameter  int N    = 8,
    localparam int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    i_req,
    input  logic [ID_W-1:0] i_last,
    output logic [N-1:0]    o_grant,
    output logic            o_valid
);

    logic [ID_W-1:0] w_idx;
    logic            w_found;
    logic [N-1:0]    w_grant;

    always_comb begin
        // NOTE: every variable written here gets a default first, so no path
        // leaves one holding its old value and no latch is inferred.
        w_grant = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int k = 1; k <= N; k++) begin
            // index arithmetic wraps in ID_W bits, giving the modulo-N search
            w_idx = i_last + ID_W'(k);
            if (!w_found && i_req[w_idx]) begin
                w_grant[w_idx] = 1'b1;
                w_found        = 1'b1;
            end
        end
    end

    assign o_grant = w_grant;
    assign o_valid = w_found;

endmodule

// File: rtl/rv32_hart_fetch_sched.sv
// Per-hart PC file and round-robin fetch scheduler for the barrel core; at
// most one instruction in flight per hart, PC loop closed by the completion port.
module rv32_hart_fetch_sched
    import rv32_pkg::*;
#(
    parameter  int              NUM_HARTS = 8,
    parameter  int              PC_W      = 32,
    parameter  logic [PC_W-1:0] RESET_PC  = PC_W'(pito_pkg::RESET_PC),
    localparam int              ID_W      = $clog2(NUM_HARTS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_HARTS-1:0] hart_en,
    output logic                 fetch_valid,
    input  logic                 fetch_ready,
    output logic [ID_W-1:0]      fetch_hart_id,
    output logic [PC_W-1:0]      fetch_pc,
    input  logic                 cmpl_valid,
    input  logic [ID_W-1:0]      cmpl_hart_id,
    input  logic                 cmpl_has_new_pc,
    input  logic [PC_W-1:0]      cmpl_next_pc,
    output logic                 err_spurious,
    output logic                 err_misalign
);

    logic [PC_W-1:0]      r_pc [NUM_HARTS];
    logic [NUM_HARTS-1:0] r_inflight;
    logic [ID_W-1:0]      r_last;
    logic                 r_fetch_valid;
    logic [ID_W-1:0]      r_fetch_hart_id;
    logic [PC_W-1:0]      r_fetch_pc;
    logic                 r_err_spurious;
    logic                 r_err_misalign;

    logic [NUM_HARTS-1:0] w_eligible;
    logic [NUM_HARTS-1:0] w_grant;
    logic                 w_grant_valid;
    logic [ID_W-1:0]      w_grant_id;
    logic                 w_load;
    logic                 w_cmpl_hit;

    // inflight is set at load, so the hart sitting in the offer register is
    // already excluded from the next search
    assign w_eligible = hart_en & ~r_inflight;
    assign w_load     = !r_fetch_valid || fetch_ready;
    assign w_cmpl_hit = cmpl_valid && r_inflight[cmpl_hart_id];

    rv32_rr_arbiter #(
        .N (NUM_HARTS)
    ) u_arb (
        .i_req   (w_eligible),
        .i_last  (r_last),
        .o_grant (w_grant),
        .o_valid (w_grant_valid)
    );

    always_comb begin
        w_grant_id = '0;
        for (int h = 0; h < NUM_HARTS; h++) begin
            if (w_grant[h]) w_grant_id = ID_W'(h);
        end
    end

    // NOTE: state is updated with non-blocking assignments only, so every
    // right-hand side below sees the pre-edge value regardless of order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the PC file is a handful of flops, not a RAM macro, so it
            // is cleared by reset like the rest of the control state.
            for (int h = 0; h < NUM_HARTS; h++) r_pc[h] <= RESET_PC;
            r_inflight      <= '0;
            r_last          <= ID_W'(NUM_HARTS - 1);
            r_fetch_valid   <= 1'b0;
            r_fetch_hart_id <= '0;
            r_fetch_pc      <= '0;
            r_err_spurious  <= 1'b0;
            r_err_misalign  <= 1'b0;
        end else begin
            r_err_spurious <= cmpl_valid && !r_inflight[cmpl_hart_id];
            r_err_misalign <= w_cmpl_hit && cmpl_has_new_pc && (cmpl_next_pc[1:0] != 2'b00);

            // a completing hart is in flight and a loaded one is not, so the
            // two updates below never touch the same hart
            if (w_cmpl_hit) begin
                r_inflight[cmpl_hart_id] <= 1'b0;
                if (cmpl_has_new_pc) r_pc[cmpl_hart_id] <= {cmpl_next_pc[PC_W-1:2], 2'b00};
            end

            if (w_load) begin
                if (w_grant_valid) begin
                    r_fetch_valid          <= 1'b1;
                    r_fetch_hart_id        <= w_grant_id;
                    r_fetch_pc             <= r_pc[w_grant_id];
                    r_inflight[w_grant_id] <= 1'b1;
                    r_pc[w_grant_id]       <= r_pc[w_grant_id] + PC_W'(PC_STEP);
                    r_last                 <= w_grant_id;
                end else begin
                    r_fetch_valid <= 1'b0;
                end
            end
        end
    end

    assign fetch_valid   = r_fetch_valid;
    assign fetch_hart_id = r_fetch_hart_id;
    assign fetch_pc      = r_fetch_pc;
    assign err_spurious  = r_err_spurious;
    assign err_misalign  = r_err_misalign;

endmodule

// File: tb/tb_rv32_hart_fetch_sched.sv
// Self-checking bench for rv32_hart_fetch_sched: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a model.
module tb_rv32_hart_fetch_sched;
    import rv32_pkg::*;
    import pito_pkg::*;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] hart_en;
    logic         fetch_valid;
    logic         fetch_ready;
    hart_id_t     fetch_hart_id;
    rv32_pc_cnt_t fetch_pc;
    logic         cmpl_valid;
    hart_id_t     cmpl_hart_id;
    logic         cmpl_has_new_pc;
    rv32_pc_cnt_t cmpl_next_pc;
    logic         err_spurious;
    logic         err_misalign;

    int checks = 0;
    int errors = 0;

    rv32_hart_fetch_sched #(
        .NUM_HARTS (N),
        .PC_W      (32),
        .RESET_PC  (RESET_PC)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .hart_en         (hart_en),
        .fetch_valid     (fetch_valid),
        .fetch_ready     (fetch_ready),
        .fetch_hart_id   (fetch_hart_id),
        .fetch_pc        (fetch_pc),
        .cmpl_valid      (cmpl_valid),
        .cmpl_hart_id    (cmpl_hart_id),
        .cmpl_has_new_pc (cmpl_has_new_pc),
        .cmpl_next_pc    (cmpl_next_pc),
        .err_spurious    (err_spurious),
        .err_misalign    (err_misalign)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: PC table, in-flight set, pointer and offer.
    rv32_pc_cnt_t m_pc [N];
    logic [N-1:0] m_infl;
    int           m_last;
    logic         m_valid;
    int           m_id;
    rv32_pc_cnt_t m_fpc;
    logic         m_sp, m_mis;

    rv32_pc_cnt_t n_pc [N];
    logic [N-1:0] n_infl;
    int           n_last;
    logic         n_valid;
    int           n_id;
    rv32_pc_cnt_t n_fpc;
    logic         n_sp, n_mis, n_found;

    always_comb begin
        n_pc    = m_pc;
        n_infl  = m_infl;
        n_last  = m_last;
        n_valid = m_valid;
        n_id    = m_id;
        n_fpc   = m_fpc;
        n_sp    = 1'b0;
        n_mis   = 1'b0;
        n_found = 1'b0;
        if (cmpl_valid) begin
            if (m_infl[cmpl_hart_id]) begin
                n_infl[cmpl_hart_id] = 1'b0;
                if (cmpl_has_new_pc) begin
                    n_pc[cmpl_hart_id] = cmpl_next_pc & ~32'h3;
                    n_mis = (cmpl_next_pc % 4) != 0;
                end
            end else begin
                n_sp = 1'b1;
            end
        end
        if (!m_valid || fetch_ready) begin
            n_valid = 1'b0;
            for (int k = 1; k <= N; k++) begin
                if (!n_found && hart_en[(m_last + k) % N] && !m_infl[(m_last + k) % N]) begin
                    n_found = 1'b1;
                    n_valid = 1'b1;
                    n_id    = (m_last + k) % N;
                    n_fpc   = m_pc[(m_last + k) % N];
                    n_pc[(m_last + k) % N]   = m_pc[(m_last + k) % N] + 32'd4;
                    n_infl[(m_last + k) % N] = 1'b1;
                    n_last  = (m_last + k) % N;
                end
            end
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int h = 0; h < N; h++) m_pc[h] <= RESET_PC;
            m_infl  <= '0;
            m_last  <= N - 1;
            m_valid <= 1'b0;
            m_id    <= 0;
            m_fpc   <= '0;
            m_sp    <= 1'b0;
            m_mis   <= 1'b0;
        end else begin
            m_pc    <= n_pc;
            m_infl  <= n_infl;
            m_last  <= n_last;
            m_valid <= n_valid;
            m_id    <= n_id;
            m_fpc   <= n_fpc;
            m_sp    <= n_sp;
            m_mis   <= n_mis;
        end
    end

    // Compare process: outputs are stable at the falling edge.
    always @(negedge clk) begin
        check("mdl_valid", fetch_valid, m_valid);
        if (m_valid) begin
            check("mdl_hart_id", fetch_hart_id, m_id);
            check("mdl_pc", fetch_pc, m_fpc);
        end
        check("mdl_err_spurious", err_spurious, m_sp);
        check("mdl_err_misalign", err_misalign, m_mis);
    end

    task automatic set_cmpl(input int id, input logic redir, input rv32_pc_cnt_t tgt);
        cmpl_valid      = 1'b1;
        cmpl_hart_id    = hart_id_t'(id);
        cmpl_has_new_pc = redir;
        cmpl_next_pc    = tgt;
    endtask

    task automatic clr_cmpl();
        cmpl_valid      = 1'b0;
        cmpl_has_new_pc = 1'b0;
    endtask

    initial begin
        int q[$];
        hart_en = '0;
        fetch_ready = 1'b0;
        cmpl_valid = 1'b0;
        cmpl_hart_id = '0;
        cmpl_has_new_pc = 1'b0;
        cmpl_next_pc = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;

        // Reset state.
        @(negedge clk);
        check("rst_valid", fetch_valid, 1'b0);
        check("rst_hart_id", fetch_hart_id, 0);
        check("rst_pc", fetch_pc, 0);
        check("rst_err_spurious", err_spurious, 1'b0);
        check("rst_err_misalign", err_misalign, 1'b0);

        // All harts enabled: hart 0..7 at RESET_PC, then idle.
        rst_n = 1'b1;
        hart_en = '1;
        fetch_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            check("sweep_valid", fetch_valid, 1'b1);
            check("sweep_hart_id", fetch_hart_id, i);
            check("sweep_pc", fetch_pc, RESET_PC);
        end
        @(negedge clk);
        check("sweep_done_valid", fetch_valid, 1'b0);

        // Redirect hart 3 to 0x100, then a plain completion gives 0x104.
        set_cmpl(3, 1'b1, 32'h100);
        @(negedge clk);
        clr_cmpl();
        @(negedge clk);
        check("redir_hart_id", fetch_hart_id, 3);
        check("redir_pc", fetch_pc, 32'h100);
        set_cmpl(3, 1'b0, 32'h0);
        @(negedge clk);
        clr_cmpl();
        @(negedge clk);
        check("seq_hart_id", fetch_hart_id, 3);
        check("seq_pc", fetch_pc, 32'h104);

        // Back-pressure: hart 5 offered and held while harts 2 and 6 free up.
        set_cmpl(5, 1'b0, 32'h0);
        @(negedge clk);
        clr_cmpl();
        fetch_ready = 1'b0;
        @(negedge clk);
        check("stall_first_id", fetch_hart_id, 5);
        check("stall_first_pc", fetch_pc, 32'h4);
        set_cmpl(2, 1'b0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 0) set_cmpl(6, 1'b0, 32'h0);
            else clr_cmpl();
            check("stall_valid", fetch_valid, 1'b1);
            check("stall_hart_id", fetch_hart_id, 5);
            check("stall_pc", fetch_pc, 32'h4);
        end
        fetch_ready = 1'b1;
        @(negedge clk);
        check("unstall_hart_id", fetch_hart_id, 6);
        check("unstall_pc", fetch_pc, 32'h4);
        @(negedge clk);
        check("unstall_next_id", fetch_hart_id, 2);
        check("unstall_next_pc", fetch_pc, 32'h4);

        // Harts 0 and 2 only, completing right after issue: 0,2,0,2,...
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        hart_en = 8'b0000_0101;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            check("alt_valid", fetch_valid, 1'b1);
            check("alt_hart_id", fetch_hart_id, (j % 2 == 0) ? 0 : 2);
            check("alt_pc", fetch_pc, (j / 2) * 4);
            set_cmpl(m_id, 1'b0, 32'h0);
        end
        @(negedge clk);
        hart_en = 8'b0000_0001;
        set_cmpl(m_id, 1'b0, 32'h0);
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            check("only_h0", fetch_valid ? fetch_hart_id : 0, 0);
            if (m_valid) set_cmpl(m_id, 1'b0, 32'h0);
            else clr_cmpl();
        end
        clr_cmpl();
        repeat (3) @(negedge clk);

        // Spurious completion for idle hart 5, then misaligned redirect of hart 0.
        set_cmpl(5, 1'b1, 32'h200);
        @(negedge clk);
        clr_cmpl();
        check("spurious_pulse", err_spurious, 1'b1);
        check("spurious_no_mis", err_misalign, 1'b0);
        @(negedge clk);
        check("spurious_once", err_spurious, 1'b0);
        set_cmpl(0, 1'b1, 32'h102);
        @(negedge clk);
        clr_cmpl();
        check("misalign_pulse", err_misalign, 1'b1);
        @(negedge clk);
        check("misalign_once", err_misalign, 1'b0);
        check("misalign_hart_id", fetch_hart_id, 0);
        check("misalign_pc", fetch_pc, 32'h100);

        // Asynchronous reset with harts 0..3 in flight.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        hart_en = 8'h0F;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", fetch_valid, 1'b0);
        check("arst_hart_id", fetch_hart_id, 0);
        check("arst_pc", fetch_pc, 0);
        check("arst_errs", {err_spurious, err_misalign}, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;
        hart_en = '1;
        set_cmpl(3, 1'b0, 32'h0);
        @(negedge clk);
        clr_cmpl();
        check("restart_hart_id", fetch_hart_id, 0);
        check("restart_pc", fetch_pc, RESET_PC);
        check("restart_spurious", err_spurious, 1'b1);

        // Randomized traffic; the compare process checks every cycle.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            fetch_ready = ($urandom % 4) != 0;
            if ($urandom % 50 == 0) hart_en = N'($urandom);
            q.delete();
            for (int h = 0; h < N; h++) if (m_infl[h]) q.push_back(h);
            case ($urandom % 8)
                0, 1, 2, 3: begin
                    if (q.size() > 0)
                        set_cmpl(q[$urandom % q.size()], 1'($urandom % 2),
                                 ($urandom % 4 == 0) ? $urandom : ($urandom & ~32'h3));
                    else clr_cmpl();
                end
                4: set_cmpl($urandom % N, 1'($urandom % 2), $urandom);
                default: clr_cmpl();
            endcase
        end
        @(negedge clk);
        clr_cmpl();
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
